pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter: DMEM_TIMEOUT, 15, max consecutive dmem_busy cycles before watchdog error.
REQ-002 SHALL have parameter: CNT_W, 4, width of the watchdog counter; it SHALL satisfy 2^CNT_W > DMEM_TIMEOUT.
REQ-003 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous reset, active-low: rst=0 resets, rst=1 runs.
REQ-005 SHALL have port: haz_count  input  2  data-hazard stall length from decode: 0 = none, 1 or 2 = cycles, 3 = illegal.
REQ-006 SHALL have port: dmem_busy  input  1  data cache not ready; the entire pipe must freeze.
REQ-007 SHALL have port: imem_busy  input  1  instruction cache not ready.
REQ-008 SHALL have port: br_flush  input  1  taken branch or jump resolved in execute; wrong-path IF/ID contents must be squashed.
REQ-009 SHALL have port: stall_if, stall_id, stall_ex, stall_mem  output  1 each  hold the corresponding pipeline register.
REQ-010 SHALL have port: bubble_id, bubble_ex, bubble_wb  output  1 each  insert a NOP into that stage.
REQ-011 SHALL have port: flush  output  1  squash the IF/ID register.
REQ-012 SHALL have port: err  output  1  illegal haz_count pulse or watchdog timeout.

Function
REQ-013 SHALL implement states IDLE, HAZ, DMEM; a 2-bit remaining-hazard register rem; a 1-bit flush_pend register; a CNT_W-bit watchdog counter wd; and a sticky wd_err register.
REQ-014 Priority, highest first: dmem_busy, then flush, then hazard, then imem_busy; outputs are combinational from the current state, registers and inputs.
REQ-015 dmem_busy=1, any state: all stall_* = 1, bubble_wb = 1, all other outputs 0 except err; next state DMEM; rem held unchanged.
REQ-016 In DMEM with dmem_busy=0: next state HAZ if rem != 0, else IDLE; pending work resumes in that same cycle per REQ-017..REQ-020.
REQ-017 br_flush=1 while dmem_busy=1 SHALL set flush_pend; flush SHALL be asserted on the first cycle with dmem_busy=0 (br_flush OR flush_pend), and flush_pend SHALL clear then.
REQ-018 Flush cycle: flush=1; any hazard request in that cycle is ignored; rem is cleared; next state IDLE.
REQ-019 IDLE, no flush, haz_count in {1,2}: stall_if = stall_id = bubble_ex = 1 in this cycle; rem <= haz_count-1; next state HAZ if haz_count=2. Total stall equals haz_count cycles, the first being combinational in the request cycle.
REQ-020 HAZ, no dmem_busy, no flush: stall_if = stall_id = bubble_ex = 1; rem decrements; return to IDLE when rem reaches 0; haz_count is ignored while in HAZ.
REQ-021 haz_count=3 in IDLE: err=1 for that cycle only; no stall; treated as 0.
REQ-022 imem_busy=1 with no higher-priority event: stall_if = 1, bubble_id = 1; no state change.
REQ-023 Watchdog: wd increments each cycle dmem_busy=1 and clears when dmem_busy=0; it saturates; when wd reaches DMEM_TIMEOUT, wd_err is set and stays set until reset.
REQ-024 err = wd_err OR (REQ-021 condition).

Reset
REQ-025 rst=0 SHALL immediately, without waiting for clk, put the state in IDLE and clear rem, flush_pend, wd and wd_err.
REQ-026 While rst=0, all outputs SHALL be 0 regardless of inputs.
REQ-027 Deassertion of rst mid-stall SHALL NOT resume the stall; the pipe starts in IDLE.

Verification
REQ-028 haz_count=2 for one cycle in IDLE -> stall_if, stall_id and bubble_ex high for exactly 2 cycles, then 0.
REQ-029 haz_count=2, then dmem_busy=1 for 3 cycles starting in the 2nd hazard cycle -> all stalls high for 3 cycles, then 1 remaining hazard cycle, then IDLE.
REQ-030 br_flush=1 and haz_count=1 in the same cycle -> flush=1, no stall_if, next cycle IDLE.
REQ-031 br_flush=1 during dmem_busy=1, with dmem released 2 cycles later -> flush=1 exactly on the first dmem_busy=0 cycle.
REQ-032 dmem_busy held high for 16 cycles (DMEM_TIMEOUT=15) -> err rises on the 15th-count edge and remains 1 until rst=0.
REQ-033 haz_count=3 -> a single-cycle err pulse with no stall; rst=0 asserted during HAZ -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: arbitrates data-cache freezes, branch
// flushes, multi-cycle data hazards and instruction-cache misses, and raises
// an error on illegal hazard requests or a data-cache watchdog timeout.
module pipe_stall_ctrl #(
  parameter int unsigned DMEM_TIMEOUT = 15,
  parameter int unsigned CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] haz_count,
  input  logic       dmem_busy,
  input  logic       imem_busy,
  input  logic       br_flush,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       bubble_id,
  output logic       bubble_ex,
  output logic       bubble_wb,
  output logic       flush,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StHaz, StDmem} state_e;

  localparam logic [CNT_W-1:0] WdMax   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WdLimit = CNT_W'(DMEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             wd_err_q, wd_err_d;

  logic s_if, s_id, s_ex, s_mem, b_id, b_ex, b_wb, fl, haz_err;
  logic in_haz;

  // Next-state and raw output decode, priority dmem > flush > hazard > imem
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    flush_pend_d = flush_pend_q;
    s_if         = 1'b0;
    s_id         = 1'b0;
    s_ex         = 1'b0;
    s_mem        = 1'b0;
    b_id         = 1'b0;
    b_ex         = 1'b0;
    b_wb         = 1'b0;
    fl           = 1'b0;
    haz_err      = 1'b0;
    // Leaving DMEM resumes any outstanding hazard in the same cycle
    in_haz       = (state_q == StHaz) || (state_q == StDmem && rem_q != 2'd0);

    if (dmem_busy) begin
      s_if    = 1'b1;
      s_id    = 1'b1;
      s_ex    = 1'b1;
      s_mem   = 1'b1;
      b_wb    = 1'b1;
      state_d = StDmem;
      if (br_flush) flush_pend_d = 1'b1;
    end else if (br_flush || flush_pend_q) begin
      fl           = 1'b1;
      rem_d        = 2'd0;
      flush_pend_d = 1'b0;
      state_d      = StIdle;
    end else if (in_haz) begin
      s_if    = 1'b1;
      s_id    = 1'b1;
      b_ex    = 1'b1;
      rem_d   = rem_q - 2'd1;
      state_d = (rem_q == 2'd1 || rem_q == 2'd0) ? StIdle : StHaz;
      if (rem_q == 2'd0) rem_d = 2'd0;
    end else begin
      state_d = StIdle;
      if (haz_count == 2'd1 || haz_count == 2'd2) begin
        s_if    = 1'b1;
        s_id    = 1'b1;
        b_ex    = 1'b1;
        rem_d   = haz_count - 2'd1;
        state_d = (haz_count == 2'd2) ? StHaz : StIdle;
      end else begin
        haz_err = (haz_count == 2'd3);
        if (imem_busy) begin
          s_if = 1'b1;
          b_id = 1'b1;
        end
      end
    end

    // Watchdog counts consecutive dmem_busy cycles and saturates
    if (!dmem_busy)        wd_d = '0;
    else if (wd_q == WdMax) wd_d = wd_q;
    else                   wd_d = wd_q + 1'b1;
    wd_err_d = wd_err_q || (wd_d >= WdLimit);
  end

  // Controller state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      rem_q        <= 2'd0;
      flush_pend_q <= 1'b0;
      wd_q         <= '0;
      wd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      flush_pend_q <= flush_pend_d;
      wd_q         <= wd_d;
      wd_err_q     <= wd_err_d;
    end
  end

  // Outputs forced low while reset is held, independent of inputs
  always_comb begin
    stall_if  = rst & s_if;
    stall_id  = rst & s_id;
    stall_ex  = rst & s_ex;
    stall_mem = rst & s_mem;
    bubble_id = rst & b_id;
    bubble_ex = rst & b_ex;
    bubble_wb = rst & b_wb;
    flush     = rst & fl;
    err       = rst & (wd_err_q | haz_err);
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl. Outputs are packed as
// {stall_if, stall_id, stall_ex, stall_mem, bubble_id, bubble_ex, bubble_wb, flush, err}.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] haz_count;
  logic       dmem_busy, imem_busy, br_flush;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       bubble_id, bubble_ex, bubble_wb, flush, err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  localparam logic [8:0] Zero = 9'b000000000;
  localparam logic [8:0] Hz   = 9'b110001000;
  localparam logic [8:0] Dm   = 9'b111100100;
  localparam logic [8:0] DmE  = 9'b111100101;
  localparam logic [8:0] Im   = 9'b100010000;
  localparam logic [8:0] ImE  = 9'b100010001;
  localparam logic [8:0] Fl   = 9'b000000010;
  localparam logic [8:0] Er   = 9'b000000001;

  pipe_stall_ctrl #(
    .DMEM_TIMEOUT(15),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .haz_count (haz_count),
    .dmem_busy (dmem_busy),
    .imem_busy (imem_busy),
    .br_flush  (br_flush),
    .stall_if  (stall_if),
    .stall_id  (stall_id),
    .stall_ex  (stall_ex),
    .stall_mem (stall_mem),
    .bubble_id (bubble_id),
    .bubble_ex (bubble_ex),
    .bubble_wb (bubble_wb),
    .flush     (flush),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {stall_if, stall_id, stall_ex, stall_mem, bubble_id, bubble_ex, bubble_wb, flush, err};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply inputs after a falling edge, then check mid-cycle before the rising edge
  task automatic cyc(input logic [1:0] h, input logic dm, input logic im, input logic br,
                     input logic [8:0] exp, input string tag);
    @(negedge clk);
    haz_count = h;
    dmem_busy = dm;
    imem_busy = im;
    br_flush  = br;
    #2;
    check(tag, outs(), exp);
  endtask

  initial begin
    rst       = 1'b0;
    haz_count = 2'd2;
    dmem_busy = 1'b1;
    imem_busy = 1'b1;
    br_flush  = 1'b1;
    #7;
    check("rst_outs_low", outs(), Zero);
    @(negedge clk);
    rst = 1'b1;
    haz_count = 2'd0; dmem_busy = 1'b0; imem_busy = 1'b0; br_flush = 1'b0;

    cyc(2'd0, 1'b0, 1'b0, 1'b0, Zero, "idle");
    // Two-cycle hazard; haz_count ignored while in HAZ
    cyc(2'd2, 1'b0, 1'b0, 1'b0, Hz,   "h2_c1");
    cyc(2'd1, 1'b0, 1'b0, 1'b0, Hz,   "h2_c2");
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Zero, "h2_done");
    cyc(2'd1, 1'b0, 1'b0, 1'b0, Hz,   "h1");
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Zero, "h1_done");
    // Hazard interrupted by a 3-cycle dmem freeze, then one remaining cycle
    cyc(2'd2, 1'b0, 1'b0, 1'b0, Hz,   "hd_c1");
    cyc(2'd0, 1'b1, 1'b0, 1'b0, Dm,   "hd_dm1");
    cyc(2'd0, 1'b1, 1'b0, 1'b0, Dm,   "hd_dm2");
    cyc(2'd0, 1'b1, 1'b0, 1'b0, Dm,   "hd_dm3");
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Hz,   "hd_resume");
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Zero, "hd_idle");
    // Flush beats a hazard request in the same cycle
    cyc(2'd1, 1'b0, 1'b0, 1'b1, Fl,   "fl_haz");
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Zero, "fl_next");
    // Branch during a dmem freeze is deferred to the first free cycle
    cyc(2'd0, 1'b1, 1'b0, 1'b1, Dm,   "fp_set");
    cyc(2'd0, 1'b1, 1'b0, 1'b0, Dm,   "fp_hold");
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Fl,   "fp_flush");
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Zero, "fp_clear");
    // Deferred flush discards an outstanding hazard
    cyc(2'd2, 1'b0, 1'b0, 1'b0, Hz,   "rc_haz");
    cyc(2'd0, 1'b1, 1'b0, 1'b1, Dm,   "rc_dm");
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Fl,   "rc_flush");
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Zero, "rc_rem_clr");
    // Instruction-cache miss and its priority below hazards
    cyc(2'd0, 1'b0, 1'b1, 1'b0, Im,   "imem");
    cyc(2'd1, 1'b0, 1'b1, 1'b0, Hz,   "haz_over_imem");
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Zero, "imem_done");
    // Illegal hazard count: one-cycle error pulse, no stall
    cyc(2'd3, 1'b0, 1'b0, 1'b0, Er,   "illegal");
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Zero, "illegal_gone");
    cyc(2'd3, 1'b0, 1'b1, 1'b0, ImE,  "illegal_imem");
    // Asynchronous reset during HAZ, no resume after release
    cyc(2'd2, 1'b0, 1'b0, 1'b0, Hz,   "ar_haz");
    rst = 1'b0;
    #1;
    check("ar_async_low", outs(), Zero);
    @(negedge clk);
    #2;
    check("ar_held_low", outs(), Zero);
    @(negedge clk);
    rst = 1'b1;
    haz_count = 2'd0;
    #2;
    check("ar_idle", outs(), Zero);
    // Watchdog: error becomes visible after 15 busy edges and is sticky
    for (int i = 1; i <= 16; i++) begin
      cyc(2'd0, 1'b1, 1'b0, 1'b0, (i <= 15) ? Dm : DmE, $sformatf("wd_%0d", i));
    end
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Er,   "wd_sticky1");
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Er,   "wd_sticky2");
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("wd_rst_low", outs(), Zero);
    @(negedge clk);
    rst = 1'b1;
    cyc(2'd0, 1'b0, 1'b0, 1'b0, Zero, "wd_cleared");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
